// File: rtl/conv2_row_feeder.sv
// conv2_row_feeder: buffers one ROWSxCOLS feature map, one row per write beat. It then
// issues sliding WIN-row groups to the conv2 stage. Each group waits for pool_end before
// the next is issued. The full sweep repeats PASSES times, then the buffer is released.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    global enable; low freezes all state and masks the pulses
//   wr_valid, wr_data     row write (pixel c in bits [c*DW +: DW]); wr_ready = accepting
//   data_out_0..3         rows grp..grp+3 of the current group
//   dout_valid            one-cycle pulse, new group presented
//   pool_end              downstream finished the current group
//   pass_idx              current pass, 0..PASSES-1
//   busy                  high outside the load phase
//   frame_done            one-cycle pulse after the last group of the last pass
//   wr_overrun            sticky write-while-not-ready flag
//
// Optional feature: define FEEDER_OVERRUN_EN to build the wr_overrun detector. Without it,
// wr_overrun is tied low. Dropped writes behave the same in both builds.
module conv2_row_feeder #(
  parameter int unsigned DW     = 8,
  parameter int unsigned COLS   = 12,
  parameter int unsigned ROWS   = 12,
  parameter int unsigned WIN    = 4,
  parameter int unsigned PASSES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_valid,
  input  logic [COLS*DW-1:0] wr_data,
  output logic               wr_ready,
  output logic [COLS*DW-1:0] data_out_0,
  output logic [COLS*DW-1:0] data_out_1,
  output logic [COLS*DW-1:0] data_out_2,
  output logic [COLS*DW-1:0] data_out_3,
  output logic               dout_valid,
  input  logic               pool_end,
  output logic [2:0]         pass_idx,
  output logic               busy,
  output logic               frame_done,
  output logic               wr_overrun
);

  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned RowBw = COLS * DW;

  typedef enum logic [1:0] {StLoad, StIssue, StWait, StDone} state_e;

  state_e             state_q;
  logic [RowW-1:0]    wr_row_q;
  logic [RowW-1:0]    grp_q;
  logic [2:0]         pass_q;
  logic               wr_ready_q;
  logic               busy_q;
  logic               dout_valid_q;
  logic               frame_done_q;
  logic [RowBw-1:0]   dout_q [WIN];
  logic [RowBw-1:0]   mem_q  [ROWS];
  logic               wr_acc;

  assign wr_acc = en && wr_valid && (state_q == StLoad);

  // Map storage has no reset; it is written only while loading.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_row_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoad;
      wr_row_q     <= '0;
      grp_q        <= '0;
      pass_q       <= '0;
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < int'(WIN); i++) dout_q[i] <= '0;
    end else if (en) begin
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (wr_valid) begin
            wr_row_q <= wr_row_q + RowW'(1);
            if (wr_row_q == RowW'(ROWS - 1)) begin
              state_q    <= StIssue;
              grp_q      <= '0;
              pass_q     <= '0;
              wr_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        StIssue: begin
          for (int i = 0; i < int'(WIN); i++) dout_q[i] <= mem_q[grp_q + RowW'(i)];
          dout_valid_q <= 1'b1;
          state_q      <= StWait;
        end
        StWait: begin
          // A pool_end coincident with the pulse belongs to the previous group; drop it.
          if (pool_end && !dout_valid_q) begin
            if (grp_q < RowW'(ROWS - WIN)) begin
              grp_q   <= grp_q + RowW'(1);
              state_q <= StIssue;
            end else if (pass_q < 3'(PASSES - 1)) begin
              pass_q  <= pass_q + 3'd1;
              grp_q   <= '0;
              state_q <= StIssue;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          frame_done_q <= 1'b1;
          wr_row_q     <= '0;
          grp_q        <= '0;
          pass_q       <= '0;
          wr_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StLoad;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Pulses are held in their registers while en is low and masked at the port. A pending
  // pulse therefore appears on the first cycle en is high again.
  assign dout_valid = dout_valid_q & en;
  assign frame_done = frame_done_q & en;
  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign pass_idx   = pass_q;
  assign data_out_0 = dout_q[0];
  assign data_out_1 = dout_q[1];
  assign data_out_2 = dout_q[2];
  assign data_out_3 = dout_q[3];

`ifdef FEEDER_OVERRUN_EN
  logic wr_overrun_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_overrun_q <= 1'b0;
    end else if (en && wr_valid && !wr_ready_q) begin
      wr_overrun_q <= 1'b1;
    end
  end
  assign wr_overrun = wr_overrun_q;
`else
  assign wr_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_conv2_row_feeder.sv
// Directed bench for conv2_row_feeder: reset values, load latency, group data, pass sequencing,
// pool_end handling, enable hold, writes while busy, and reset in the middle of a map.
module tb_conv2_row_feeder;

  logic        clk = 1'b0;
  logic        rst, en, wr_valid, pool_end;
  logic [95:0] wr_data;
  logic        wr_ready, dout_valid, busy, frame_done, wr_overrun;
  logic [95:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [2:0]  pass_idx;
  logic [95:0] dout_arr [4];

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int n_fd = 0;

  conv2_row_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .dout_valid (dout_valid),
    .pool_end   (pool_end),
    .pass_idx   (pass_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .wr_overrun (wr_overrun)
  );

  always #5 clk = ~clk;

  assign dout_arr[0] = data_out_0;
  assign dout_arr[1] = data_out_1;
  assign dout_arr[2] = data_out_2;
  assign dout_arr[3] = data_out_3;

  always @(negedge clk) begin
    if (dout_valid) n_pulse++;
    if (frame_done) n_fd++;
  end

  // pixel(r,c) = 16*r + c, scrambled per map so different maps are distinguishable
  function automatic logic [95:0] row_of(input int map, input int r);
    logic [95:0] res;
    logic [7:0]  p;
    for (int c = 0; c < 12; c++) begin
      p = 8'((16 * r + c) & 255);
      if (map == 1) p = p ^ 8'h5A;
      if (map == 2) p = p ^ 8'hC3;
      res[c*8 +: 8] = p;
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_map(input int map);
    for (int r = 0; r < 12; r++) begin
      wr_valid = 1'b1;
      wr_data  = row_of(map, r);
      step();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  // Returns pool_end three cycles after the current pulse and expects pulse number n
  task automatic advance(input int map, input int n);
    int grp;
    int pass;
    grp  = (n - 1) % 9;
    pass = (n - 1) / 9;
    repeat (3) step();
    pool_end = 1'b1;
    step();
    pool_end = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL adv_early pulse %0d: dout_valid=%b expected 0", n, dout_valid);
    end
    step();
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL adv_latency pulse %0d: dout_valid=%b expected 1", n, dout_valid);
    end
    checks++;
    if (pass_idx !== 3'(pass)) begin
      errors++;
      $display("FAIL adv_pass pulse %0d: pass_idx=%0d expected %0d", n, pass_idx, pass);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_arr[i] !== row_of(map, grp + i)) begin
        errors++;
        $display("FAIL adv_data pulse %0d out%0d: got %h expected %h", n, i, dout_arr[i],
                 row_of(map, grp + i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({wr_ready, busy, dout_valid, frame_done, wr_overrun} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 10000",
               {wr_ready, busy, dout_valid, frame_done, wr_overrun});
    end
    checks++;
    if (pass_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_pass: got %0d expected 0", pass_idx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_arr[i] !== 96'd0) begin
        errors++;
        $display("FAIL reset_data out%0d: got %h expected 0", i, dout_arr[i]);
      end
    end
  endtask

  task automatic test_load_latency();
    load_map(0);
    checks++;
    if ({wr_ready, busy, dout_valid} !== 3'b010) begin
      errors++;
      $display("FAIL load_t1 ready/busy/valid: got %b expected 010", {wr_ready, busy, dout_valid});
    end
    step();
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_t2 dout_valid: got %b expected 1", dout_valid);
    end
    checks++;
    if (data_out_3[7:0] !== 8'h30) begin
      errors++;
      $display("FAIL first_pix out3: got %h expected 30", data_out_3[7:0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_arr[i] !== row_of(0, i)) begin
        errors++;
        $display("FAIL first_group out%0d: got %h expected %h", i, dout_arr[i], row_of(0, i));
      end
    end
  endtask

  task automatic test_pool_end_on_pulse();
    int extra;
    extra = 0;
    pool_end = 1'b1;
    step();
    pool_end = 1'b0;
    repeat (5) begin
      if (dout_valid) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL pulse_cycle_pool_end: got %0d extra pulses expected 0", extra);
    end
    advance(0, 2);
  endtask

  task automatic test_en_hold();
    int seen;
    seen = 0;
    step();
    en       = 1'b0;
    pool_end = 1'b1;
    repeat (5) begin
      step();
      if (dout_valid || frame_done) seen++;
    end
    en       = 1'b1;
    pool_end = 1'b0;
    repeat (4) begin
      step();
      if (dout_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL en_hold: got %0d pulses expected 0", seen);
    end
    advance(0, 3);
  endtask

  task automatic test_write_in_wait();
    logic exp_ovr;
`ifdef FEEDER_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    step();
    wr_valid = 1'b1;
    wr_data  = {96{1'b1}};
    repeat (3) step();
    wr_valid = 1'b0;
    wr_data  = '0;
    checks++;
    if (wr_overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun: got %b expected %b", wr_overrun, exp_ovr);
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_wait: got %b expected 0", wr_ready);
    end
    advance(0, 4);
  endtask

  task automatic test_full_run();
    for (int n = 5; n <= 27; n++) begin
      advance(0, n);
      if (n == 9) begin
        checks++;
        if (data_out_0[7:0] !== 8'h80) begin
          errors++;
          $display("FAIL ninth_pix out0: got %h expected 80", data_out_0[7:0]);
        end
      end
    end
    repeat (3) step();
    pool_end = 1'b1;
    step();
    pool_end = 1'b0;
    checks++;
    if ({frame_done, wr_ready, dout_valid} !== 3'b000) begin
      errors++;
      $display("FAIL done_early fd/ready/valid: got %b expected 000",
               {frame_done, wr_ready, dout_valid});
    end
    step();
    checks++;
    if ({frame_done, wr_ready, busy, dout_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL done_pulse fd/ready/busy/valid: got %b expected 1100",
               {frame_done, wr_ready, busy, dout_valid});
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: frame_done=%b expected 0", frame_done);
    end
    repeat (3) step();
    checks++;
    if (n_pulse !== 27) begin
      errors++;
      $display("FAIL pulse_count: got %0d expected 27", n_pulse);
    end
    checks++;
    if (n_fd !== 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 1", n_fd);
    end
  endtask

  task automatic test_reset_mid();
    load_map(1);
    step();
    for (int n = 2; n <= 5; n++) advance(1, n);
    rst = 1'b1;
    #2;
    checks++;
    if ({wr_ready, busy, dout_valid, frame_done, wr_overrun, pass_idx} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b expected 10000000",
               {wr_ready, busy, dout_valid, frame_done, wr_overrun, pass_idx});
    end
    checks++;
    if (data_out_0 !== 96'd0 || data_out_3 !== 96'd0) begin
      errors++;
      $display("FAIL mid_reset_data: got %h / %h expected 0", data_out_0, data_out_3);
    end
    step();
    rst = 1'b0;
    step();
    load_map(2);
    step();
    checks++;
    if (dout_valid !== 1'b1 || pass_idx !== 3'd0) begin
      errors++;
      $display("FAIL reload_pulse valid/pass: got %b/%0d expected 1/0", dout_valid, pass_idx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_arr[i] !== row_of(2, i)) begin
        errors++;
        $display("FAIL reload_data out%0d: got %h expected %h", i, dout_arr[i], row_of(2, i));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    pool_end = 1'b0;
    test_reset();
    test_load_latency();
    test_pool_end_on_pulse();
    test_en_hold();
    test_write_in_wait();
    test_full_run();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
